// File: rtl/bf16_mul_seq.sv
// bf16_mul_seq: multi-cycle BF16 multiplier feeding a PE result register.
// Iterative radix-2 shift-add mantissa multiply, RNE rounding, flush-to-zero,
// fixed 11-cycle latency from accepted start to the done pulse.
module bf16_mul_seq #(
    parameter logic [15:0] QNAN = 16'h7FC0
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        start,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    output logic [15:0] product,
    output logic        done,
    output logic        busy
);

    localparam int unsigned W  = 16;  // BF16 word
    localparam int unsigned EW = 8;   // exponent field
    localparam int unsigned FW = 7;   // fraction field
    localparam int unsigned MW = 8;   // mantissa with hidden bit
    localparam int unsigned PW = 16;  // mantissa product, 2.14
    localparam int unsigned XW = 10;  // signed exponent arithmetic
    localparam int unsigned CW = 3;   // multiply step counter

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_MULT,
        S_NORM,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // captured operands
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;

    // unpacked operands and special-case classification
    logic          r_sign;
    logic [EW-1:0] r_ea;
    logic [EW-1:0] r_eb;
    logic [MW-1:0] r_ma;
    logic [MW-1:0] r_mb;
    logic          r_spec;
    logic [W-1:0]  r_spec_val;

    // shift-add multiplier
    logic [PW-1:0] r_acc;
    logic [CW-1:0] r_cnt;

    // result staging and outputs
    logic [W-1:0]  r_res;
    logic [W-1:0]  r_product;
    logic          r_done;
    logic          r_busy;

    // unpack combinational signals
    logic [EW-1:0] w_a_exp;
    logic [EW-1:0] w_b_exp;
    logic [FW-1:0] w_a_frac;
    logic [FW-1:0] w_b_frac;
    logic          w_sign;
    logic          w_a_zero;
    logic          w_b_zero;
    logic          w_a_inf;
    logic          w_b_inf;
    logic          w_a_nan;
    logic          w_b_nan;
    logic          w_spec;
    logic [W-1:0]  w_spec_val;

    // normalise / round combinational signals
    logic signed [XW-1:0] w_e_sum;
    logic signed [XW-1:0] w_e_norm;
    logic signed [XW-1:0] w_e_fin;
    logic [FW-1:0]        w_frac;
    logic                 w_guard;
    logic                 w_sticky;
    logic                 w_round_up;
    logic [MW-1:0]        w_frac_rnd;
    logic [FW-1:0]        w_frac_fin;
    logic [W-1:0]         w_res;

    // multiply step addend
    logic [PW-1:0]        w_addend;

    assign product = r_product;
    assign done    = r_done;
    assign busy    = r_busy;

    // State register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start is only honoured in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_UNPACK;
            S_UNPACK: w_state_nxt = S_MULT;
            S_MULT:   if (r_cnt == CW'(7)) w_state_nxt = S_NORM;
            S_NORM:   w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Field split and operand classification; exp=0 counts as zero (denormal flush)
    always_comb begin
        w_a_exp  = r_a[W-2 -: EW];
        w_b_exp  = r_b[W-2 -: EW];
        w_a_frac = r_a[FW-1:0];
        w_b_frac = r_b[FW-1:0];
        w_sign   = r_a[W-1] ^ r_b[W-1];
        w_a_zero = (w_a_exp == '0);
        w_b_zero = (w_b_exp == '0);
        w_a_inf  = (w_a_exp == '1) && (w_a_frac == '0);
        w_b_inf  = (w_b_exp == '1) && (w_b_frac == '0);
        w_a_nan  = (w_a_exp == '1) && (w_a_frac != '0);
        w_b_nan  = (w_b_exp == '1) && (w_b_frac != '0);
    end

    // Special-case result, highest priority first
    always_comb begin
        w_spec     = 1'b0;
        w_spec_val = '0;
        if (w_a_nan || w_b_nan) begin
            w_spec     = 1'b1;
            w_spec_val = QNAN;
        end else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            w_spec     = 1'b1;
            w_spec_val = QNAN;
        end else if (w_a_inf || w_b_inf) begin
            w_spec     = 1'b1;
            w_spec_val = {w_sign, {EW{1'b1}}, {FW{1'b0}}};
        end else if (w_a_zero || w_b_zero) begin
            w_spec     = 1'b1;
            w_spec_val = {w_sign, {(W-1){1'b0}}};
        end
    end

    // Partial product for the current multiplier bit
    always_comb begin
        w_addend = '0;
        if (r_mb[r_cnt]) begin
            w_addend = PW'(r_ma) << r_cnt;
        end
    end

    // Normalise, round to nearest even, range-check the exponent
    always_comb begin
        w_e_sum = XW'({2'b00, r_ea}) + XW'({2'b00, r_eb}) - XW'(127);
        if (r_acc[PW-1]) begin
            w_frac   = r_acc[PW-2 -: FW];
            w_guard  = r_acc[PW-2-FW];
            w_sticky = |r_acc[PW-3-FW:0];
            w_e_norm = w_e_sum + XW'(1);
        end else begin
            w_frac   = r_acc[PW-3 -: FW];
            w_guard  = r_acc[PW-3-FW];
            w_sticky = |r_acc[PW-4-FW:0];
            w_e_norm = w_e_sum;
        end
        w_round_up = w_guard & (w_sticky | w_frac[0]);
        w_frac_rnd = MW'({1'b0, w_frac}) + MW'(w_round_up);
        if (w_frac_rnd[MW-1]) begin
            w_frac_fin = '0;
            w_e_fin    = w_e_norm + XW'(1);
        end else begin
            w_frac_fin = w_frac_rnd[FW-1:0];
            w_e_fin    = w_e_norm;
        end

        if (r_spec) begin
            w_res = r_spec_val;
        end else if (w_e_fin >= 10'sd255) begin
            w_res = {r_sign, {EW{1'b1}}, {FW{1'b0}}};
        end else if (w_e_fin <= 10'sd0) begin
            w_res = {r_sign, {(W-1){1'b0}}};
        end else begin
            w_res = {r_sign, w_e_fin[EW-1:0], w_frac_fin};
        end
    end

    // Datapath: capture, unpack, shift-add steps, result staging
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_sign     <= 1'b0;
            r_ea       <= '0;
            r_eb       <= '0;
            r_ma       <= '0;
            r_mb       <= '0;
            r_spec     <= 1'b0;
            r_spec_val <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_res      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a <= a_in;
                        r_b <= b_in;
                    end
                end
                S_UNPACK: begin
                    r_sign     <= w_sign;
                    r_ea       <= w_a_exp;
                    r_eb       <= w_b_exp;
                    r_ma       <= w_a_zero ? '0 : {1'b1, w_a_frac};
                    r_mb       <= w_b_zero ? '0 : {1'b1, w_b_frac};
                    r_spec     <= w_spec;
                    r_spec_val <= w_spec_val;
                    r_acc      <= '0;
                    r_cnt      <= '0;
                end
                S_MULT: begin
                    r_acc <= r_acc + w_addend;
                    r_cnt <= CW'(r_cnt + CW'(1));
                end
                S_NORM: begin
                    r_res <= w_res;
                end
                default: begin
                end
            endcase
        end
    end

    // Output registers: product loads only on DONE, done pulses once, busy tracks activity
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_product <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            if (r_state == S_DONE) begin
                r_product <= r_res;
            end
            r_done <= (r_state == S_DONE);
            r_busy <= (w_state_nxt != S_IDLE);
        end
    end

endmodule

// File: doc/bf16_mul_seq.md
Name: bf16_mul_seq

Overview:
- Multi-cycle BFLOAT16 multiplier that sits directly upstream of the result register in each systolic-array PE.
- Accepts two BF16 operands on a start strobe and computes the product with an iterative shift-add mantissa multiplier.
- Presents the rounded BF16 product together with a one-cycle `done` pulse, which drives the result register's load enable.

Parameters:
- QNAN, 16'h7FC0, canonical quiet NaN returned for every invalid or NaN case.

Ports:
- clk  input  1  rising-edge clock.
- clr_n  input  1  asynchronous active-low reset.
- start  input  1  operand-valid strobe; accepted only in IDLE.
- a_in  input  16  BF16 operand A.
- b_in  input  16  BF16 operand B.
- product  output  16  BF16 result; holds its value until the next `done`.
- done  output  1  one-cycle pulse, asserted with `product` valid; feeds the result register's `en`.
- busy  output  1  high from the cycle after `start` is accepted until `done` is asserted.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - `clr_n`=0 immediately forces state=IDLE, product=16'h0000, done=0, busy=0, and clears all internal registers.
  - Reset asserted mid-operation aborts the operation; no `done` is issued.
- FSM states: IDLE -> UNPACK -> MULT -> NORM -> DONE -> IDLE.
  - IDLE: on start=1, capture `a_in`/`b_in` and go to UNPACK. start=0 stays in IDLE.
  - UNPACK (1 cycle): split sign/exp/frac, prepend the hidden bit to form 8-bit mantissas, and classify special cases.
    - exp=0 is treated as zero; denormals are flushed to zero.
  - MULT (exactly 8 cycles): radix-2 shift-add of two 8-bit mantissas into a 16-bit accumulator. A 3-bit counter runs 0..7.
  - NORM (1 cycle): normalise, round to nearest even, compute exponent, resolve special cases.
  - DONE (1 cycle): `product` register loads, done=1, busy drops; next state IDLE.
- Latency: fixed 11 cycles. For `start` sampled at edge N, `done`=1 and the new `product` are visible after edge N+11.
  - Special-case operands take the same fixed latency.
  - Throughput is one operation per 12 cycles.
- `start` while busy=1 is ignored; no queuing.
  - `start` in the same cycle as DONE is also ignored.
  - `start` is accepted from the IDLE cycle that follows.
- Arithmetic:
  - Sign = sa XOR sb.
  - Exponent uses a 10-bit signed sum: e = ea + eb - 127.
  - Mantissa product P[15:0] is in 2.14 format.
    - If P[15]=1: frac = P[14:8], guard = P[7], sticky = |P[6:0], e = e + 1.
    - Otherwise: frac = P[13:7], guard = P[6], sticky = |P[5:0].
  - RNE rounding: round up iff guard & (sticky | frac[0]).
    - A rounding carry out of frac sets frac=0 and increments e.
  - Overflow: e >= 255 after rounding -> {sign, 8'hFF, 7'h00} (signed infinity).
  - Underflow: e <= 0 -> {sign, 15'h0} (signed zero, flush).
- Special-case priority, highest first:
  1. Any NaN operand -> QNAN.
  2. Inf × 0 -> QNAN.
  3. Inf × finite or Inf × Inf -> signed Inf.
  4. 0 × finite -> signed zero.
- `product` is unchanged in every state except DONE.

Test Plan:
- Basic: a=3F80, b=3F80 (1×1) -> done exactly 11 cycles after start, product=3F80; product stays 3F80 with done=0 afterwards.
- Exponent and normalise path: 4000×4040 (2×3) -> 40C0. 3FC0×3FC0 (1.5²) -> 4010, exercising P[15]=1. C000×3F00 -> BF80.
- RNE tie to even: 3F81×3FC0 -> 3FC2 (65.5 rounds to 66). 3F81×3F81 -> 3F82 (guard=0, round down).
- Specials:
  - 7F7F×7F7F -> 7F80 (overflow).
  - 7F80×0000 -> 7FC0.
  - 7FC1×3F80 -> 7FC0.
  - 8000×4000 -> 8000.
  - 0080×0080 -> 0000 (underflow).
  - All of the above with 11-cycle latency.
- Handshake: pulse start again at cycles +3 and +11 of a busy operation -> both ignored, exactly one done. A start in the following IDLE cycle is accepted.
- Reset: drop `clr_n` at MULT cycle 4 -> product=0000, busy=0 immediately, no done. After release, a new start completes normally.
